// File: rtl/rtc_cmd_parser_if.sv
// Byte-stream input and RTC write-path outputs of the ASCII command parser.
// slave = parser side, master = UART receiver / RTC write path side.
interface rtc_cmd_parser_if;
    logic       rxDone;
    logic [7:0] rxData;
    logic [7:0] secData;
    logic [7:0] minData;
    logic [7:0] hrsData;
    logic [7:0] dateData;
    logic [7:0] monData;
    logic [7:0] yrData;
    logic [7:0] dayData;
    logic       timeWr;
    logic       dateWr;
    logic       err;
    logic [1:0] errCode;
    logic       busy;

    modport slave (
        input  rxDone, rxData,
        output secData, minData, hrsData, dateData, monData, yrData, dayData,
        output timeWr, dateWr, err, errCode, busy
    );

    modport master (
        output rxDone, rxData,
        input  secData, minData, hrsData, dateData, monData, yrData, dayData,
        input  timeWr, dateWr, err, errCode, busy
    );
endinterface

// File: rtl/rtc_cmd_parser.sv
// Parses "T hh:mm:ss" / "D yy/mm/dd w" lines into packed-BCD RTC fields.
// Optional range validation is enabled by defining RTC_PARSER_RANGE_CHECK_EN.
module rtc_cmd_parser #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TIMEOUT_MS = 1000
) (
    input  logic             clk,
    input  logic             rst,
    rtc_cmd_parser_if.slave  bus
);
    localparam int unsigned TIMEOUT_CLKS = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int unsigned TO_W         = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned STAGE_W      = 28;

    localparam logic [IDX_W-1:0] T_LAST = IDX_W'(9);
    localparam logic [IDX_W-1:0] D_LAST = IDX_W'(11);

    localparam logic [1:0] ERR_SYNTAX  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
`ifdef RTC_PARSER_RANGE_CHECK_EN
    localparam logic [1:0] ERR_RANGE   = 2'd2;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } stateT;

    stateT              state, stateN;
    logic [IDX_W-1:0]   idx, idxN;
    logic               isDate, isDateN;
    logic [STAGE_W-1:0] stage, stageN;
    logic [TO_W-1:0]    toCnt, toCntN;

    logic [7:0] secQ, minQ, hrsQ, dateQ, monQ, yrQ, dayQ;
    logic [7:0] secN, minN, hrsN, dateN, monN, yrN, dayN;
    logic       timeWrQ, dateWrQ, errQ, busyQ;
    logic       timeWrN, dateWrN, errN, busyN;
    logic [1:0] errCodeQ, errCodeN;

    logic             isEol, isDigit, isTimeLetter, isDateLetter;
    logic [IDX_W-1:0] lastIdx;
    logic             tplDigit;
    logic [7:0]       tplChar;
    logic             timeOk, dateOk;
    logic             toExpire;

    // Byte classification and template character at the current index
    always_comb begin
        isEol        = (bus.rxData == 8'h0D) || (bus.rxData == 8'h0A);
        isDigit      = (bus.rxData >= 8'h30) && (bus.rxData <= 8'h39);
        isTimeLetter = (bus.rxData == 8'h54) || (bus.rxData == 8'h74);
        isDateLetter = (bus.rxData == 8'h44) || (bus.rxData == 8'h64);
        lastIdx      = isDate ? D_LAST : T_LAST;
        tplDigit     = 1'b0;
        tplChar      = 8'h20;
        case (idx)
            4'd1, 4'd2, 4'd4, 4'd5, 4'd7, 4'd8, 4'd10: tplDigit = 1'b1;
            4'd3, 4'd6: tplChar = isDate ? 8'h2F : 8'h3A;
            default:    tplChar = 8'h20;
        endcase
    end

    // Staged BCD layout: time = hh[23:16] mm[15:8] ss[7:0]; date = yy[27:20] mm[19:12] dd[11:4] w[3:0]
    always_comb begin
`ifdef RTC_PARSER_RANGE_CHECK_EN
        timeOk = (stage[23:16] <= 8'h23) && (stage[15:8] <= 8'h59) && (stage[7:0] <= 8'h59);
        dateOk = (stage[19:12] >= 8'h01) && (stage[19:12] <= 8'h12) &&
                 (stage[11:4]  >= 8'h01) && (stage[11:4]  <= 8'h31) &&
                 (stage[3:0]   >= 4'd1)  && (stage[3:0]   <= 4'd7);
`else
        timeOk = 1'b1;
        dateOk = 1'b1;
`endif
    end

    // A byte arriving in the expiry cycle wins over the timeout
    always_comb begin
        toExpire = (TIMEOUT_CLKS != 0) && (state != IDLE) && !bus.rxDone &&
                   (toCnt == TO_W'(TIMEOUT_CLKS - 1));
        toCntN   = (bus.rxDone || state == IDLE) ? '0 : toCnt + TO_W'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        stateN   = state;
        idxN     = idx;
        isDateN  = isDate;
        stageN   = stage;
        secN     = secQ;
        minN     = minQ;
        hrsN     = hrsQ;
        dateN    = dateQ;
        monN     = monQ;
        yrN      = yrQ;
        dayN     = dayQ;
        timeWrN  = 1'b0;
        dateWrN  = 1'b0;
        errN     = 1'b0;
        errCodeN = errCodeQ;

        case (state)
            IDLE: begin
                if (bus.rxDone && (isTimeLetter || isDateLetter)) begin
                    stateN  = RECV;
                    idxN    = '0;
                    isDateN = isDateLetter;
                    stageN  = '0;
                end
            end

            RECV: begin
                if (bus.rxDone) begin
                    if (isEol) begin
                        stateN = IDLE;
                        if (idx != lastIdx) begin
                            errN     = 1'b1;
                            errCodeN = ERR_SYNTAX;
                        end else if (!isDate) begin
                            if (timeOk) begin
                                hrsN    = stage[23:16];
                                minN    = stage[15:8];
                                secN    = stage[7:0];
                                timeWrN = 1'b1;
                            end else begin
                                errN     = 1'b1;
`ifdef RTC_PARSER_RANGE_CHECK_EN
                                errCodeN = ERR_RANGE;
`endif
                            end
                        end else begin
                            if (dateOk) begin
                                yrN     = stage[27:20];
                                monN    = stage[19:12];
                                dateN   = stage[11:4];
                                dayN    = {4'h0, stage[3:0]};
                                dateWrN = 1'b1;
                            end else begin
                                errN     = 1'b1;
`ifdef RTC_PARSER_RANGE_CHECK_EN
                                errCodeN = ERR_RANGE;
`endif
                            end
                        end
                    end else if (idx == lastIdx) begin
                        stateN = DISCARD;
                    end else if (tplDigit) begin
                        if (isDigit) begin
                            stageN = {stage[STAGE_W-5:0], bus.rxData[3:0]};
                            idxN   = idx + IDX_W'(1);
                        end else begin
                            stateN = DISCARD;
                        end
                    end else if (bus.rxData == tplChar) begin
                        idxN = idx + IDX_W'(1);
                    end else begin
                        stateN = DISCARD;
                    end
                end else if (toExpire) begin
                    stateN   = IDLE;
                    errN     = 1'b1;
                    errCodeN = ERR_TIMEOUT;
                end
            end

            DISCARD: begin
                if (bus.rxDone && isEol) begin
                    stateN   = IDLE;
                    errN     = 1'b1;
                    errCodeN = ERR_SYNTAX;
                end else if (toExpire) begin
                    stateN   = IDLE;
                    errN     = 1'b1;
                    errCodeN = ERR_TIMEOUT;
                end
            end

            default: stateN = IDLE;
        endcase

        busyN = (stateN != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            isDate   <= 1'b0;
            stage    <= '0;
            toCnt    <= '0;
            secQ     <= 8'h00;
            minQ     <= 8'h00;
            hrsQ     <= 8'h00;
            dateQ    <= 8'h00;
            monQ     <= 8'h00;
            yrQ      <= 8'h00;
            dayQ     <= 8'h01;
            timeWrQ  <= 1'b0;
            dateWrQ  <= 1'b0;
            errQ     <= 1'b0;
            errCodeQ <= 2'd0;
            busyQ    <= 1'b0;
        end else begin
            state    <= stateN;
            idx      <= idxN;
            isDate   <= isDateN;
            stage    <= stageN;
            toCnt    <= toCntN;
            secQ     <= secN;
            minQ     <= minN;
            hrsQ     <= hrsN;
            dateQ    <= dateN;
            monQ     <= monN;
            yrQ      <= yrN;
            dayQ     <= dayN;
            timeWrQ  <= timeWrN;
            dateWrQ  <= dateWrN;
            errQ     <= errN;
            errCodeQ <= errCodeN;
            busyQ    <= busyN;
        end
    end

    assign bus.secData  = secQ;
    assign bus.minData  = minQ;
    assign bus.hrsData  = hrsQ;
    assign bus.dateData = dateQ;
    assign bus.monData  = monQ;
    assign bus.yrData   = yrQ;
    assign bus.dayData  = dayQ;
    assign bus.timeWr   = timeWrQ;
    assign bus.dateWr   = dateWrQ;
    assign bus.err      = errQ;
    assign bus.errCode  = errCodeQ;
    assign bus.busy     = busyQ;
endmodule

// File: tb/tb_rtc_cmd_parser.sv
// Directed bench for rtc_cmd_parser; timeout configured to 10 clocks.
module tb_rtc_cmd_parser;
    logic clk;
    logic rst;
    int   total     = 0;
    int   bad       = 0;
    int   strobeCnt = 0;
    int   snap;
    int   waited;

    rtc_cmd_parser_if bus ();

    rtc_cmd_parser #(.CLK_HZ(10_000), .TIMEOUT_MS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.rxDone = 1'b1;
        bus.rxData = b;
        tick();
        bus.rxDone = 1'b0;
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
    endtask

    task automatic chkTime(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        chk({tag, "_hrs"}, 32'(bus.hrsData), 32'(h));
        chk({tag, "_min"}, 32'(bus.minData), 32'(m));
        chk({tag, "_sec"}, 32'(bus.secData), 32'(s));
    endtask

    task automatic chkDate(input string tag, input logic [7:0] y, input logic [7:0] m,
                           input logic [7:0] d, input logic [7:0] w);
        chk({tag, "_yr"},  32'(bus.yrData),   32'(y));
        chk({tag, "_mon"}, 32'(bus.monData),  32'(m));
        chk({tag, "_date"}, 32'(bus.dateData), 32'(d));
        chk({tag, "_day"}, 32'(bus.dayData),  32'(w));
    endtask

    // Strobes must be mutually exclusive; also count them for no-strobe windows
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            total++;
            assert ($onehot0({bus.timeWr, bus.dateWr, bus.err})) else begin
                bad++;
                $error("FAIL strobe_exclusive: observed=%b expected=onehot0",
                       {bus.timeWr, bus.dateWr, bus.err});
            end
            if (bus.timeWr || bus.dateWr || bus.err) strobeCnt++;
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: observed=stuck expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        bus.rxDone = 1'b0;
        bus.rxData = 8'h00;
        repeat (3) tick();
        rst = 1'b1;

        chkTime("rst", 8'h00, 8'h00, 8'h00);
        chkDate("rst", 8'h00, 8'h00, 8'h00, 8'h01);
        chk("rst_timeWr", 32'(bus.timeWr), 0);
        chk("rst_dateWr", 32'(bus.dateWr), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_errCode", 32'(bus.errCode), 0);
        chk("rst_busy", 32'(bus.busy), 0);

        // Basic set-time
        sendByte("T");
        chk("t1_busy_letter", 32'(bus.busy), 1);
        sendStr(" 12:34:56");
        chk("t1_no_strobe", 32'(bus.timeWr), 0);
        sendByte(8'h0D);
        chk("t1_timeWr", 32'(bus.timeWr), 1);
        chk("t1_busy_end", 32'(bus.busy), 0);
        chkTime("t1", 8'h12, 8'h34, 8'h56);
        chkDate("t1", 8'h00, 8'h00, 8'h00, 8'h01);
        tick();
        chk("t1_timeWr_pulse", 32'(bus.timeWr), 0);

        // Lowercase set-date with LF
        sendStr("d 25/12/31 4");
        sendByte(8'h0A);
        chk("d1_dateWr", 32'(bus.dateWr), 1);
        chkDate("d1", 8'h25, 8'h12, 8'h31, 8'h04);
        chkTime("d1", 8'h12, 8'h34, 8'h56);
        tick();
        chk("d1_dateWr_pulse", 32'(bus.dateWr), 0);

        // Literal mismatch
        sendStr("T 12-34:56");
        chk("syn_busy", 32'(bus.busy), 1);
        chk("syn_no_err_yet", 32'(bus.err), 0);
        sendByte(8'h0D);
        chk("syn_err", 32'(bus.err), 1);
        chk("syn_code", 32'(bus.errCode), 1);
        chk("syn_busy_end", 32'(bus.busy), 0);
        chkTime("syn", 8'h12, 8'h34, 8'h56);

        // Hour out of range
        sendStr("T 24:00:00");
        sendByte(8'h0D);
`ifdef RTC_PARSER_RANGE_CHECK_EN
        chk("rng_t_err", 32'(bus.err), 1);
        chk("rng_t_code", 32'(bus.errCode), 2);
        chkTime("rng_t", 8'h12, 8'h34, 8'h56);
`else
        chk("rng_t_timeWr", 32'(bus.timeWr), 1);
        chkTime("rng_t", 8'h24, 8'h00, 8'h00);
`endif

        // Month, date and weekday all zero
        sendStr("D 99/00/00 0");
        sendByte(8'h0D);
`ifdef RTC_PARSER_RANGE_CHECK_EN
        chk("rng_d_err", 32'(bus.err), 1);
        chk("rng_d_code", 32'(bus.errCode), 2);
        chkDate("rng_d", 8'h25, 8'h12, 8'h31, 8'h04);
`else
        chk("rng_d_dateWr", 32'(bus.dateWr), 1);
        chkDate("rng_d", 8'h99, 8'h00, 8'h00, 8'h00);
`endif
        tick();

        // Inter-byte timeout
        sendStr("T 1");
        waited = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.err) begin
                waited = n;
                break;
            end
        end
        chk("to_latency", 32'(waited), 10);
        chk("to_code", 32'(bus.errCode), 3);
        chk("to_busy", 32'(bus.busy), 0);
        tick();

        // Byte in the expiry cycle keeps the command alive
        sendStr("T 0");
        repeat (9) tick();
        sendByte("1");
        chk("to_edge_err", 32'(bus.err), 0);
        chk("to_edge_busy", 32'(bus.busy), 1);
        sendStr(":02:03");
        sendByte(8'h0D);
        chk("to_edge_timeWr", 32'(bus.timeWr), 1);
        chkTime("to_edge", 8'h01, 8'h02, 8'h03);
        chk("to_edge_code_held", 32'(bus.errCode), 3);

        // EOL before the final index
        sendStr("T 12:3");
        sendByte(8'h0D);
        chk("early_eol_err", 32'(bus.err), 1);
        chk("early_eol_code", 32'(bus.errCode), 1);
        chkTime("early_eol", 8'h01, 8'h02, 8'h03);

        // Extra character where EOL is expected
        sendStr("T 01:02:033");
        chk("long_busy", 32'(bus.busy), 1);
        sendByte(8'h0D);
        chk("long_err", 32'(bus.err), 1);
        chkTime("long", 8'h01, 8'h02, 8'h03);

        // Stray bytes in idle are ignored
        tick();
        snap = strobeCnt;
        sendByte("x");
        sendByte(8'h0D);
        tick();
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_no_strobe", 32'(strobeCnt), 32'(snap));

        // Reset in the middle of a command
        sendStr("T 01:");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_code", 32'(bus.errCode), 0);
        chkTime("mid_rst", 8'h00, 8'h00, 8'h00);
        chk("mid_rst_day", 32'(bus.dayData), 32'h01);
        snap = strobeCnt;
        sendStr("T 05:06:07");
        chk("mid_rst_no_strobe", 32'(strobeCnt), 32'(snap));
        sendByte(8'h0D);
        chk("mid_rst_timeWr", 32'(bus.timeWr), 1);
        chkTime("mid_rst_new", 8'h05, 8'h06, 8'h07);

        // Next command starts during the strobe cycle
        sendStr("D 00/01/01 7");
        sendByte(8'h0D);
        chk("b2b_dateWr", 32'(bus.dateWr), 1);
        chkDate("b2b", 8'h00, 8'h01, 8'h01, 8'h07);
        sendByte("t");
        chk("b2b_busy", 32'(bus.busy), 1);
        chk("b2b_dateWr_pulse", 32'(bus.dateWr), 0);
        sendStr(" 23:59:59");
        sendByte(8'h0A);
        chk("b2b_timeWr", 32'(bus.timeWr), 1);
        chkTime("b2b", 8'h23, 8'h59, 8'h59);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rtc_cmd_parser.md
# rtc_cmd_parser

Receive-side command decoder for the UART/RTC subsystem. Consumes the byte stream from the UART receiver (`rxDone` / `rxData`) and parses ASCII set-time and set-date commands into packed-BCD RTC register values. It is the inverse of the transmit formatter, which renders RTC BCD fields to text. On a valid line it presents the new fields with a one-cycle write strobe to the RTC write path; on a malformed line it raises an error strobe with a cause code.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz
- `TIMEOUT_MS`, 1000, maximum inter-byte gap inside a command before abort; 0 disables the timeout

- `clk`  input  1  system clock
- `rst`  input  1  synchronous, active-low reset
- `rxDone`  input  1  one-cycle strobe, `rxData` valid
- `rxData`  input  8  received ASCII byte
- `secData`, `minData`, `hrsData`  output  8 each  BCD time fields; updated only on a valid `T` command
- `dateData`, `monData`, `yrData`  output  8 each  BCD date fields; updated only on a valid `D` command
- `dayData`  output  8  BCD day-of-week, 0x01–0x07; updated only on a valid `D` command
- `timeWr`  output  1  one-cycle strobe: time fields were just updated
- `dateWr`  output  1  one-cycle strobe: date fields were just updated
- `err`  output  1  one-cycle strobe: command rejected
- `errCode`  output  2  cause of last `err`: 1 = syntax, 2 = range, 3 = timeout; holds until the next `err`
- `busy`  output  1  high while a command is in progress (`RECV` or `DISCARD`)

## Operation
- Command grammar (EOL = 0x0D or 0x0A):
  - `T hh:mm:ss`EOL
  - `D yy/mm/dd w`EOL
  - Command letters are case-insensitive. Whitespace is exactly the single spaces shown.
- States:
  - `IDLE`:
    - `T`/`t`/`D`/`d` → `RECV` with idx = 0 and cmd latched.
    - Any other byte, including EOL, is ignored silently.
  - `RECV`: each byte is compared with the template character at idx.
    - Digit positions accept 0x30–0x39 only; the nibble (byte − 0x30) is shifted into a staging register.
    - Literal positions (space, `:`, `/`) require an exact match.
    - On mismatch → `DISCARD`, pending code 1.
    - EOL at the final index → validate, commit, → `IDLE`.
    - EOL at any other index is a syntax error: `err` fires, code 1, → `IDLE`.
  - `DISCARD`: drop bytes until EOL, then pulse `err` with the pending code and return to `IDLE`.
- Template lengths, letter excluded, EOL included: T = 10, D = 12. idx is 4 bits.
- Validation runs at EOL on the staging register; the output fields are not touched until it passes.
  - Time: hh ≤ 23, mm ≤ 59, ss ≤ 59.
  - Date: mm 01–12, dd 01–31, w 1–7. yy is any value 00–99.
  - No month-length check.
  - Failure → `err`, code 2, outputs unchanged.
- Commit is atomic: all fields of the command update in the same cycle as the strobe.
- Timeout:
  - A counter runs while `busy` and is cleared by every `rxDone`.
  - Reaching TIMEOUT_CLKS = CLK_HZ/1000·TIMEOUT_MS → `err`, code 3, → `IDLE`. Staged data is dropped.
- `dayData` upper nibble is always 0.

## Timing
- Reset (`rst` = 0 at a clock edge):
  - All BCD outputs 0x00, except `dayData` = 0x01.
  - `timeWr` = `dateWr` = `err` = 0, `errCode` = 0, `busy` = 0, state `IDLE`.
  - Reset mid-command discards the command; no strobe follows.
- Latency: `timeWr`/`dateWr`/`err` are registered and assert in the cycle after the `rxDone` cycle carrying EOL. Updated fields are valid in that same cycle.
- `busy` rises the cycle after the letter byte and falls together with the terminating strobe.
- At most one of `timeWr`, `dateWr`, `err` is high in any cycle.
- Back-to-back bytes on consecutive cycles are accepted. An `rxDone` during a strobe cycle is processed normally.
- `rxDone` in the same cycle as timeout expiry: the byte wins, the counter clears, and no timeout occurs.

## Configuration
- `RTC_PARSER_RANGE_CHECK_EN`:
  - Defined: range validation as above; code 2 is possible.
  - Undefined: only syntax is checked. Any digit values commit (e.g. `T 99:99:99` gives `hrsData` = 0x99). `errCode` 2 is never produced.

## Test plan
- After reset, `T 12:34:56\r` → 1 cycle after CR: `timeWr` = 1 for one cycle; `hrsData` = 0x12, `minData` = 0x34, `secData` = 0x56; date fields unchanged.
- `d 25/12/31 4\n` → `dateWr` pulse; `yrData` = 0x25, `monData` = 0x12, `dateData` = 0x31, `dayData` = 0x04.
- `T 12-34:56\r` → `err` one cycle after CR with `errCode` = 1; time fields keep their prior values; `busy` is high from the letter until the strobe.
- `T 24:00:00\r` with the macro defined → `err`, `errCode` = 2, outputs unchanged. With the macro undefined → `timeWr` and `hrsData` = 0x24.
- `TIMEOUT_MS` = 1, `CLK_HZ` = 10_000: send `T 1` then idle 10 cycles → `err`, `errCode` = 3. Then `T 01:02:03\r` → `timeWr`, `hrsData` = 0x01.
- Send `T 01:` then assert `rst` low for one cycle, then `T 05:06:07\r` → no strobe before the final CR; after it, `timeWr` with 0x05/0x06/0x07.
